// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter.
//   arb_state_t : bus owner state (IDLE, IMEM fetch, DMEM data access)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMEM = 2'd1,
        DMEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_port_hold.sv
// Per-port completion tracking for mem_arbiter.
// Remembers that a port's access finished while the pipeline was stalled, so
// the arbiter does not issue it again. Also keeps the returned data stable
// until the pipeline advances.
//   clk, reset      : clock, synchronous active-high reset
//   pipe_enable     : pipeline advances this cycle (clears done)
//   req             : port request
//   ack_this_port   : bus ack for a transaction owned by this port
//   bus_rdata       : slave read data
//   done            : access finished, waiting for the pipeline to advance
//   port_wait       : port stall to the hazard unit
//   rdata           : read data presented to the core
module mem_port_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_enable,
    input  logic                  req,
    input  logic                  ack_this_port,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  done,
    output logic                  port_wait,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] hold_reg;

    // A pipeline advance always clears done, even in the same cycle as an ack:
    // the core consumes bus_rdata directly in that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            hold_reg <= '0;
        end else if (pipe_enable) begin
            done     <= 1'b0;
        end else if (ack_this_port) begin
            done     <= 1'b1;
            hold_reg <= bus_rdata;
        end
    end

    assign port_wait = req && !done && !ack_this_port;
    assign rdata     = done ? hold_reg : bus_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory bus between instruction fetch and data
// access. Data accesses win when both are pending in IDLE. A running fetch is
// never preempted. Bus request fields are registered when a transaction starts
// and stay stable until the slave acks.
//   clk, reset                  : clock, synchronous active-high reset
//   pipe_enable                 : pipeline advances this cycle
//   imem_req/addr, imem_rdata/wait : fetch port
//   dmem_req/we/be/addr/wdata, dmem_rdata/wait : data port
//   bus_req/we/be/addr/wdata    : registered request to the slave
//   bus_ack, bus_rdata          : slave completion and read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_enable,
    input  logic                    imem_req,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    imem_wait,
    input  logic                    dmem_req,
    input  logic                    dmem_we,
    input  logic [DATA_WIDTH/8-1:0] dmem_be,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_wait,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    arb_state_t state_q, state_d;
    logic       load_i, load_d;
    logic       imem_done, dmem_done;
    logic       imem_pend, dmem_pend;
    logic       imem_ack, dmem_ack;

    assign imem_ack  = (state_q == IMEM) && bus_ack;
    assign dmem_ack  = (state_q == DMEM) && bus_ack;
    assign imem_pend = imem_req && !imem_done;
    assign dmem_pend = dmem_req && !dmem_done;
    assign bus_req   = (state_q != IDLE);

    mem_port_hold #(.DATA_WIDTH(DATA_WIDTH)) u_imem_hold (
        .clk           (clk),
        .reset         (reset),
        .pipe_enable   (pipe_enable),
        .req           (imem_req),
        .ack_this_port (imem_ack),
        .bus_rdata     (bus_rdata),
        .done          (imem_done),
        .port_wait     (imem_wait),
        .rdata         (imem_rdata)
    );

    mem_port_hold #(.DATA_WIDTH(DATA_WIDTH)) u_dmem_hold (
        .clk           (clk),
        .reset         (reset),
        .pipe_enable   (pipe_enable),
        .req           (dmem_req),
        .ack_this_port (dmem_ack),
        .bus_rdata     (bus_rdata),
        .done          (dmem_done),
        .port_wait     (dmem_wait),
        .rdata         (dmem_rdata)
    );

    // On ack the bus hands over directly to the other port, so back-to-back
    // accesses have no idle cycle between them.
    always_comb begin
        state_d = state_q;
        load_i  = 1'b0;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_pend) begin
                    state_d = DMEM;
                    load_d  = 1'b1;
                end else if (imem_pend) begin
                    state_d = IMEM;
                    load_i  = 1'b1;
                end
            end
            IMEM: begin
                if (bus_ack) begin
                    if (dmem_pend) begin
                        state_d = DMEM;
                        load_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DMEM: begin
                if (bus_ack) begin
                    if (imem_pend) begin
                        state_d = IMEM;
                        load_i  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (load_d) begin
                bus_we    <= dmem_we;
                bus_be    <= dmem_be;
                bus_addr  <= dmem_addr;
                bus_wdata <= dmem_wdata;
            end else if (load_i) begin
                bus_we    <= 1'b0;
                bus_be    <= '1;
                bus_addr  <= imem_addr;
                bus_wdata <= '0;
            end
        end
    end

    // A port must keep its request up until its own transaction is acked.
    a_imem_req_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == IMEM) |-> imem_req);
    a_dmem_req_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == DMEM) |-> dmem_req);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_wait;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_enable (pipe_enable),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_wait   (imem_wait),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_wait   (dmem_wait),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_be      (bus_be),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    // One row per clock cycle: inputs driven for that cycle and the outputs
    // expected during it.
    typedef struct {
        logic        rst, pe, ireq;
        logic [31:0] ia;
        logic        dreq, dwe;
        logic [3:0]  dbe;
        logic [31:0] da, dwd;
        logic        ack;
        logic [31:0] rd;
        logic        e_breq, e_bwe;
        logic [3:0]  e_bbe;
        logic [31:0] e_ba, e_bwd;
        logic        e_iw, e_dw;
        logic [31:0] e_ird, e_drd;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        pipe_enable = v.pe;
        imem_req    = v.ireq;
        imem_addr   = v.ia;
        dmem_req    = v.dreq;
        dmem_we     = v.dwe;
        dmem_be     = v.dbe;
        dmem_addr   = v.da;
        dmem_wdata  = v.dwd;
        bus_ack     = v.ack;
        bus_rdata   = v.rd;
    endtask

    initial begin
        int n;
        int busy;
        logic got;

        // reset with both requests high, then store+fetch back-to-back
        tbl[0]  = '{1'b1,1'b0,1'b1,32'h104, 1'b1,1'b1,4'hF,32'h200,32'hDEADBEEF, 1'b0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b1, 32'h0,32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b1,32'h104, 1'b1,1'b1,4'hF,32'h200,32'hDEADBEEF, 1'b0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b1, 32'h0,32'h0};
        tbl[2]  = '{1'b0,1'b0,1'b1,32'h104, 1'b1,1'b1,4'hF,32'h200,32'hDEADBEEF, 1'b1,32'h11111111,
                    1'b1,1'b1,4'hF,32'h200,32'hDEADBEEF, 1'b1,1'b0, 32'h11111111,32'h11111111};
        tbl[3]  = '{1'b0,1'b1,1'b1,32'h104, 1'b1,1'b1,4'hF,32'h200,32'hDEADBEEF, 1'b1,32'h00000093,
                    1'b1,1'b0,4'hF,32'h104,32'h0, 1'b0,1'b0, 32'h00000093,32'h11111111};
        tbl[4]  = '{1'b0,1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h104,32'h0, 1'b0,1'b0, 32'h0,32'h0};
        // single zero-wait fetch
        tbl[5]  = '{1'b0,1'b0,1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h104,32'h0, 1'b1,1'b0, 32'h0,32'h0};
        tbl[6]  = '{1'b0,1'b1,1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h13,
                    1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,1'b0, 32'h13,32'h13};
        tbl[7]  = '{1'b0,1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h100,32'h0, 1'b0,1'b0, 32'h0,32'h0};
        // load acked under stall, slave data then changes
        tbl[8]  = '{1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h100,32'h0, 1'b0,1'b1, 32'h0,32'h0};
        tbl[9]  = '{1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0, 1'b1,32'hCAFE0300,
                    1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,1'b0, 32'hCAFE0300,32'hCAFE0300};
        tbl[10] = '{1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h55555555,
                    1'b0,1'b0,4'hF,32'h300,32'h0, 1'b0,1'b0, 32'h55555555,32'hCAFE0300};
        tbl[11] = '{1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0, 1'b0,32'h55555555,
                    1'b0,1'b0,4'hF,32'h300,32'h0, 1'b0,1'b0, 32'h55555555,32'hCAFE0300};
        tbl[12] = '{1'b0,1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h300,32'h0, 1'b0,1'b0, 32'h0,32'h0};
        // slow slave fetch, store arrives mid-transaction
        tbl[13] = '{1'b0,1'b0,1'b1,32'h400, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h300,32'h0, 1'b1,1'b0, 32'h0,32'h0};
        for (int i = 14; i <= 16; i++)
            tbl[i] = '{1'b0,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,32'h0,
                       1'b1,1'b0,4'hF,32'h400,32'h0, 1'b1,1'b1, 32'h0,32'h0};
        tbl[17] = '{1'b0,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b1,32'h0BADF00D,
                    1'b1,1'b0,4'hF,32'h400,32'h0, 1'b0,1'b1, 32'h0BADF00D,32'h0BADF00D};
        tbl[18] = '{1'b0,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,32'h0,
                    1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,1'b1, 32'h0BADF00D,32'h0};
        // reset in DMEM before ack
        tbl[19] = '{1'b1,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,32'h0,
                    1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,1'b1, 32'h0BADF00D,32'h0};
        tbl[20] = '{1'b0,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b1, 32'h0,32'h0};
        tbl[21] = '{1'b0,1'b0,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b1,32'h0,
                    1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b1,1'b0, 32'h0,32'h0};
        tbl[22] = '{1'b0,1'b1,1'b1,32'h400, 1'b1,1'b1,4'h3,32'h500,32'h12345678, 1'b1,32'h77,
                    1'b1,1'b0,4'hF,32'h400,32'h0, 1'b0,1'b0, 32'h77,32'h0};
        tbl[23] = '{1'b0,1'b1,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,4'hF,32'h400,32'h0, 1'b0,1'b0, 32'h0,32'h0};

        drive(tbl[0]);
        imem_req = 1'b0;
        dmem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d bus_req", i),    {31'b0, bus_req},   {31'b0, tbl[i].e_breq});
            chk($sformatf("row%0d bus_we", i),     {31'b0, bus_we},    {31'b0, tbl[i].e_bwe});
            chk($sformatf("row%0d bus_be", i),     {28'b0, bus_be},    {28'b0, tbl[i].e_bbe});
            chk($sformatf("row%0d bus_addr", i),   bus_addr,           tbl[i].e_ba);
            chk($sformatf("row%0d bus_wdata", i),  bus_wdata,          tbl[i].e_bwd);
            chk($sformatf("row%0d imem_wait", i),  {31'b0, imem_wait}, {31'b0, tbl[i].e_iw});
            chk($sformatf("row%0d dmem_wait", i),  {31'b0, dmem_wait}, {31'b0, tbl[i].e_dw});
            chk($sformatf("row%0d imem_rdata", i), imem_rdata,         tbl[i].e_ird);
            chk($sformatf("row%0d dmem_rdata", i), dmem_rdata,         tbl[i].e_drd);
            @(posedge clk);
            #1;
        end

        // Fetch against a slave with 2 wait states: imem_wait must stay high
        // for 1 + 2 cycles, bounded at 20 cycles.
        reset = 1'b0; pipe_enable = 1'b0;
        imem_req = 1'b1; imem_addr = 32'h600;
        dmem_req = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        n = 0; busy = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus_ack   = bus_req && (busy == 2);
            bus_rdata = bus_ack ? 32'h600DD00D : 32'h0;
            @(negedge clk);
            if (bus_req)
                chk("slow bus_addr", bus_addr, 32'h600);
            if (!imem_wait) begin
                got = 1'b1;
                chk("slow imem_rdata", imem_rdata, 32'h600DD00D);
                break;
            end
            n++;
            if (bus_req) busy++;
            @(posedge clk);
            #1;
        end
        chk("slow completed", {31'b0, got}, 32'd1);
        chk("slow wait cycles", n, 32'd3);
        @(posedge clk);
        #1;
        bus_ack = 1'b0; pipe_enable = 1'b1; imem_req = 1'b0;
        @(negedge clk);
        chk("slow end bus_req", {31'b0, bus_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
